// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared types and opcode constants for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    localparam int c_CNT_W_DEF        = 32;
    localparam int c_MEM_WAIT_MAX_DEF = 16;
    localparam int c_OP_W             = 7;
    localparam int c_F3_W             = 3;

    // RV32I major opcodes
    localparam logic [c_OP_W-1:0] c_OP_R3    = 7'b0110011;
    localparam logic [c_OP_W-1:0] c_OP_IMM   = 7'b0010011;
    localparam logic [c_OP_W-1:0] c_OP_LUI   = 7'b0110111;
    localparam logic [c_OP_W-1:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [c_OP_W-1:0] c_OP_JAL   = 7'b1101111;
    localparam logic [c_OP_W-1:0] c_OP_JALR  = 7'b1100111;
    localparam logic [c_OP_W-1:0] c_OP_BR    = 7'b1100011;
    localparam logic [c_OP_W-1:0] c_OP_LD    = 7'b0000011;
    localparam logic [c_OP_W-1:0] c_OP_ST    = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'd0,
        PC_IMM     = 2'd1,
        PC_RS1_IMM = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        TC_NONE     = 2'd0,
        TC_ILLEGAL  = 2'd1,
        TC_IMEM_TO  = 2'd2,
        TC_DMEM_TO  = 2'd3
    } trap_cause_t;

    function automatic logic op_is_legal(input logic [c_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            c_OP_R3, c_OP_IMM, c_OP_LUI, c_OP_AUIPC, c_OP_JAL,
            c_OP_JALR, c_OP_BR, c_OP_LD, c_OP_ST: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Instruction/data memory request-acknowledge handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic                imem_req;
    logic                imem_ready;
    logic                dmem_req;
    logic                dmem_ready;
    logic                dmem_we;
    logic [c_F3_W-1:0]   dmem_size;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        output dmem_size,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        input  dmem_size,
        output imem_ready,
        output dmem_ready
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_mem_wait_timer
// Description : Memory wait counter with clear/enable and a timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_timeout
);

    localparam int             c_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(MEM_WAIT_MAX - 1);

    logic [c_W-1:0] r_cnt;

    // Counter parks at the last value; the FSM leaves the waiting state there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_timeout) begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign o_timeout = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Fetch/decode/exec/mem/write-back control FSM for an RV32I core.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = c_MEM_WAIT_MAX_DEF,
    parameter int CNT_W        = c_CNT_W_DEF
) (
    input  wire logic               clk,
    input  wire logic               reset,
    multicycle_ctrl_if.master       mem,
    input  wire logic [c_OP_W-1:0]  op,
    input  wire logic [c_F3_W-1:0]  funct3,
    input  wire logic               branch_taken,
    output logic                    ir_we,
    output logic                    alu_a_sel,
    output logic                    alu_b_sel,
    output logic                    reg_we,
    output logic [1:0]              wb_sel,
    output logic                    pc_we,
    output logic [1:0]              pc_sel,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        instret_cnt
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_OP_W-1:0]   r_op;
    logic [c_F3_W-1:0]   r_funct3;
    logic                r_trap;
    trap_cause_t         r_trap_cause;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_instret_cnt;

    logic                w_retire;
    trap_cause_t         w_trap_cause;
    logic                w_timeout;
    logic                w_wait_clr;
    logic                w_wait_en;

    multicycle_ctrl_mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_wait_clr),
        .i_en      (w_wait_en),
        .o_timeout (w_timeout)
    );

    // One timer serves both FETCH and MEM; any state change restarts it.
    assign w_wait_clr = (w_state_nxt != r_state);
    assign w_wait_en  = (r_state == S_FETCH) || (r_state == S_MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_retire      = 1'b0;
        w_trap_cause  = TC_NONE;
        mem.imem_req  = 1'b0;
        mem.dmem_req  = 1'b0;
        mem.dmem_we   = 1'b0;
        mem.dmem_size = '0;
        ir_we         = 1'b0;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        reg_we        = 1'b0;
        wb_sel        = WB_ALU;
        pc_we         = 1'b0;
        pc_sel        = PC_PLUS4;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                mem.imem_req = 1'b1;
                // A ready in the last allowed cycle still wins over the timeout.
                if (mem.imem_ready) begin
                    ir_we       = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_trap_cause = TC_IMEM_TO;
                    w_state_nxt  = S_TRAP;
                end
            end

            S_DECODE: begin
                if (op_is_legal(op)) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_trap_cause = TC_ILLEGAL;
                    w_state_nxt  = S_TRAP;
                end
            end

            S_EXEC: begin
                case (r_op)
                    c_OP_IMM, c_OP_LD, c_OP_ST, c_OP_JALR: begin
                        alu_b_sel = 1'b1;
                    end
                    c_OP_AUIPC, c_OP_JAL, c_OP_BR: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase

                if (r_op == c_OP_BR) begin
                    pc_we       = 1'b1;
                    pc_sel      = branch_taken ? PC_IMM : PC_PLUS4;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if ((r_op == c_OP_LD) || (r_op == c_OP_ST)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end

            S_MEM: begin
                mem.dmem_req  = 1'b1;
                mem.dmem_we   = (r_op == c_OP_ST);
                mem.dmem_size = r_funct3;
                if (mem.dmem_ready) begin
                    if (r_op == c_OP_ST) begin
                        pc_we       = 1'b1;
                        pc_sel      = PC_PLUS4;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_timeout) begin
                    w_trap_cause = TC_DMEM_TO;
                    w_state_nxt  = S_TRAP;
                end
            end

            S_WB: begin
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
                case (r_op)
                    c_OP_LD:             wb_sel = WB_LOAD;
                    c_OP_JAL, c_OP_JALR: wb_sel = WB_PC4;
                    c_OP_LUI:            wb_sel = WB_IMM;
                    default:             wb_sel = WB_ALU;
                endcase
                case (r_op)
                    c_OP_JAL:  pc_sel = PC_IMM;
                    c_OP_JALR: pc_sel = PC_RS1_IMM;
                    default:   pc_sel = PC_PLUS4;
                endcase
            end

            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_funct3 <= '0;
        end else if (r_state == S_DECODE) begin
            r_op     <= op;
            r_funct3 <= funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trap       <= 1'b0;
            r_trap_cause <= TC_NONE;
        end else if ((r_state != S_TRAP) && (w_state_nxt == S_TRAP)) begin
            r_trap       <= 1'b1;
            r_trap_cause <= w_trap_cause;
        end
    end

    // Both counters wrap freely; cycle_cnt keeps running in TRAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    assign trap        = r_trap;
    assign trap_cause  = r_trap_cause;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed, scoreboard-checked bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int MEM_WAIT_MAX = 16;
    localparam int CNT_W        = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              branch_taken;
    logic              ir_we, alu_a_sel, alu_b_sel, reg_we, pc_we, trap;
    logic [1:0]        wb_sel, pc_sel, trap_cause;
    logic [CNT_W-1:0]  cycle_cnt, instret_cnt;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mif),
        .op           (op),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responders: ready after a programmable number of wait cycles.
    int imem_delay = 0, dmem_delay = 0;
    bit imem_stall = 0, dmem_stall = 0;
    int i_wait = 0, d_wait = 0;

    initial begin
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mif.imem_req === 1'b1) begin
                mif.imem_ready = !imem_stall && (i_wait >= imem_delay);
                i_wait++;
            end else begin
                mif.imem_ready = 1'b0;
                i_wait = 0;
            end
            if (mif.dmem_req === 1'b1) begin
                mif.dmem_ready = !dmem_stall && (d_wait >= dmem_delay);
                d_wait++;
            end else begin
                mif.dmem_ready = 1'b0;
                d_wait = 0;
            end
        end
    end

    // Scoreboard: one entry per issued instruction, popped on its pc_we strobe.
    typedef struct {
        int         id;
        logic       rw;
        logic [1:0] wb;
        logic [1:0] pc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   fetch_start = 0;
    logic prev_req = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if ((mif.imem_req === 1'b1) && !prev_req) fetch_start = cyc;
        prev_req = (mif.imem_req === 1'b1);
        if (pc_we === 1'b1) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("sb%0d_reg_we", e.id), 32'(reg_we), 32'(e.rw));
                chk($sformatf("sb%0d_wb_sel", e.id), 32'(wb_sel), 32'(e.wb));
                chk($sformatf("sb%0d_pc_sel", e.id), 32'(pc_sel), 32'(e.pc));
                chk($sformatf("sb%0d_latency", e.id), 32'(cyc - fetch_start + 1), 32'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic issue(input int id, input logic [6:0] o, input logic [2:0] f3,
                         input logic bt, input int dly, input logic rw,
                         input logic [1:0] wb, input logic [1:0] pc, input int lat);
        exp_t e;
        op = o; funct3 = f3; branch_taken = bt; dmem_delay = dly;
        e.id = id; e.rw = rw; e.wb = wb; e.pc = pc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run_to_retire(input string tag, input logic [31:0] target, input int bound,
                                 output int reqc, output int wec, output int rwc,
                                 output logic [2:0] sz, output logic [1:0] ab);
        int k;
        k = 0; reqc = 0; wec = 0; rwc = 0; sz = '0; ab = '0;
        while ((instret_cnt !== target) && (k < bound)) begin
            tick();
            k++;
            if (mif.dmem_req === 1'b1) begin
                reqc++;
                if (mif.dmem_we === 1'b1) wec++;
                sz = mif.dmem_size;
            end
            if (reg_we === 1'b1) rwc++;
            ab = ab | {alu_a_sel, alu_b_sel};
        end
        chk({tag, "_retire"}, instret_cnt, target);
    endtask

    typedef struct {
        logic [6:0] o;
        logic [2:0] f3;
        logic       rw;
        logic [1:0] wb;
        logic [1:0] pc;
        int         lat;
        int         we;
        logic [1:0] ab;
    } tbl_t;

    tbl_t tbl [5];

    initial begin
        int reqc, wec, rwc, cnt, k;
        logic [2:0] sz;
        logic [1:0] ab;
        logic [31:0] c0;

        tbl[0] = '{c_OP_ST,    3'b000, 1'b0, 2'd0, 2'd0, 4, 1, 2'b01};
        tbl[1] = '{c_OP_LUI,   3'b000, 1'b1, 2'd3, 2'd0, 4, 0, 2'b00};
        tbl[2] = '{c_OP_JAL,   3'b000, 1'b1, 2'd2, 2'd1, 4, 0, 2'b11};
        tbl[3] = '{c_OP_AUIPC, 3'b000, 1'b1, 2'd0, 2'd0, 4, 0, 2'b11};
        tbl[4] = '{c_OP_R3,    3'b000, 1'b1, 2'd0, 2'd0, 4, 0, 2'b00};

        reset = 1'b1; op = c_OP_IMM; funct3 = 3'b000; branch_taken = 1'b0;
        tick(); tick();
        chk("rst_imem_req", 32'(mif.imem_req), 0);
        chk("rst_dmem_req", 32'(mif.dmem_req), 0);
        chk("rst_strobes", 32'({ir_we, reg_we, pc_we, alu_a_sel, alu_b_sel}), 0);
        chk("rst_trap", 32'({trap, trap_cause}), 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instret_cnt", instret_cnt, 0);

        // ADDI, zero-wait memory, walked state by state
        issue(1, c_OP_IMM, 3'b000, 1'b0, 0, 1'b1, 2'd0, 2'd0, 4);
        reset = 1'b0;
        tick();
        chk("addi_fetch_req", 32'(mif.imem_req), 1);
        chk("addi_fetch_ir_we", 32'(ir_we), 1);
        tick();
        chk("addi_decode_req", 32'(mif.imem_req), 0);
        tick();
        chk("addi_exec_ab", 32'({alu_a_sel, alu_b_sel}), 32'b01);
        tick();
        chk("addi_wb_reg_we", 32'(reg_we), 1);
        chk("addi_wb_sel", 32'(wb_sel), 0);
        tick();
        chk("addi_instret", instret_cnt, 1);
        chk("addi_cycle_cnt", cycle_cnt, 5);

        // LW with three wait states on data memory
        issue(2, c_OP_LD, 3'b010, 1'b0, 3, 1'b1, 2'd1, 2'd0, 8);
        run_to_retire("lw", 2, 30, reqc, wec, rwc, sz, ab);
        chk("lw_dmem_req_cycles", 32'(reqc), 4);
        chk("lw_dmem_we_cycles", 32'(wec), 0);
        chk("lw_dmem_size", 32'(sz), 32'b010);

        // Branch taken, then not taken
        issue(3, c_OP_BR, 3'b000, 1'b1, 0, 1'b0, 2'd0, 2'd1, 3);
        run_to_retire("beq_t", 3, 20, reqc, wec, rwc, sz, ab);
        chk("beq_t_reg_we", 32'(rwc), 0);
        issue(4, c_OP_BR, 3'b000, 1'b0, 0, 1'b0, 2'd0, 2'd0, 3);
        run_to_retire("beq_n", 4, 20, reqc, wec, rwc, sz, ab);
        chk("beq_n_reg_we", 32'(rwc), 0);

        // JALR: check operand selects in EXEC explicitly
        issue(5, c_OP_JALR, 3'b000, 1'b0, 0, 1'b1, 2'd2, 2'd2, 4);
        tick();
        tick();
        chk("jalr_exec_ab", 32'({alu_a_sel, alu_b_sel}), 32'b01);
        run_to_retire("jalr", 5, 20, reqc, wec, rwc, sz, ab);

        for (int i = 0; i < 5; i++) begin
            issue(10 + i, tbl[i].o, tbl[i].f3, 1'b0, 0, tbl[i].rw, tbl[i].wb, tbl[i].pc, tbl[i].lat);
            run_to_retire($sformatf("tbl%0d", i), 32'(6 + i), 20, reqc, wec, rwc, sz, ab);
            chk($sformatf("tbl%0d_dmem_we", i), 32'(wec), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_alu_ab", i), 32'(ab), 32'(tbl[i].ab));
        end

        // Illegal opcode traps after DECODE and stays there
        op = 7'b1111111;
        tick();
        tick();
        chk("ill_trap", 32'(trap), 1);
        chk("ill_cause", 32'(trap_cause), 1);
        c0 = cycle_cnt;
        cnt = 0;
        repeat (5) begin
            tick();
            if (mif.imem_req === 1'b1) cnt++;
        end
        chk("ill_no_imem_req", 32'(cnt), 0);
        chk("ill_cycle_cnt_runs", cycle_cnt, c0 + 32'd5);
        chk("ill_instret_frozen", instret_cnt, 10);
        chk("sb_drained", 32'(sb.size()), 0);

        // Instruction fetch never acknowledged
        reset = 1'b1; imem_stall = 1'b1; op = c_OP_IMM;
        tick();
        reset = 1'b0;
        cnt = 0; k = 0;
        while ((trap !== 1'b1) && (k < 40)) begin
            tick();
            k++;
            if (mif.imem_req === 1'b1) cnt++;
        end
        chk("ito_fetch_cycles", 32'(cnt), 16);
        chk("ito_trap", 32'(trap), 1);
        chk("ito_cause", 32'(trap_cause), 2);

        // Ready in the timeout cycle must beat the timeout
        reset = 1'b1; imem_stall = 1'b0; imem_delay = 15;
        tick();
        issue(20, c_OP_IMM, 3'b000, 1'b0, 0, 1'b1, 2'd0, 2'd0, 19);
        reset = 1'b0;
        run_to_retire("edge", 1, 40, reqc, wec, rwc, sz, ab);
        chk("edge_no_trap", 32'(trap), 0);
        imem_delay = 0;

        // Data memory never acknowledged
        op = c_OP_LD; funct3 = 3'b010; dmem_stall = 1'b1;
        cnt = 0; k = 0;
        while ((trap !== 1'b1) && (k < 40)) begin
            tick();
            k++;
            if (mif.dmem_req === 1'b1) cnt++;
        end
        chk("dto_req_cycles", 32'(cnt), 16);
        chk("dto_cause", 32'(trap_cause), 3);
        chk("dto_instret", instret_cnt, 1);

        // Reset asserted in the middle of MEM
        reset = 1'b1;
        tick();
        reset = 1'b0;
        k = 0;
        while ((mif.dmem_req !== 1'b1) && (k < 20)) begin
            tick();
            k++;
        end
        chk("mid_reached_mem", 32'(mif.dmem_req), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({mif.imem_req, mif.dmem_req, mif.dmem_we, mif.dmem_size,
                                    ir_we, reg_we, pc_we, alu_a_sel, alu_b_sel,
                                    wb_sel, pc_sel, trap, trap_cause}), 0);
        chk("mid_rst_cycle_cnt", cycle_cnt, 0);
        tick();
        chk("mid_rst_no_strobe", 32'({reg_we, pc_we}), 0);
        chk("mid_rst_instret", instret_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
